// File: rtl/csi_lane_align.sv
// Deskews NUM_LANES D-PHY HS byte lanes into one aligned word; the first word appears two edges after
// the edge that samples the latest lane's first byte, whatever the skew. There is no backpressure: words stream at line rate.
module csi_lane_align #(
    parameter  int NUM_LANES = 2,
    parameter  int MAX_SKEW  = 2,
    localparam int DW        = $clog2(MAX_SKEW + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_LANES-1:0]    lane_valid,
    input  logic [NUM_LANES*8-1:0]  lane_data,
    output logic [NUM_LANES*8-1:0]  word_out,
    output logic                    word_valid,
    output logic                    locked,
    output logic [NUM_LANES*DW-1:0] lane_delay,
    output logic                    skew_err,
    output logic                    desync_err
);

    localparam int DEPTH = MAX_SKEW + 2;
    localparam int SW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [NUM_LANES-1:0]                 lane_valid_q;
    logic [NUM_LANES-1:0][DEPTH-1:0][8:0] dl_q, dl_d;
    logic [NUM_LANES-1:0]                 arrived_q, arrived_d;
    logic [NUM_LANES-1:0][DW-1:0]         arr_q, arr_d;
    logic [NUM_LANES-1:0][DW-1:0]         delay_q, delay_d;
    logic [DW-1:0]                        c_q, c_d;
    logic [NUM_LANES*8-1:0]               word_q, word_d;
    logic                                 word_valid_q, word_valid_d;
    logic                                 skew_err_q, skew_err_d;
    logic                                 desync_err_q, desync_err_d;

    logic [NUM_LANES-1:0]                 rise;
    logic [NUM_LANES-1:0]                 av;
    logic [NUM_LANES*8-1:0]               aw;

    // Tap delay+1: the latest lane's first byte sits in stage 0 after the lock edge,
    // so one extra stage gives a fixed two-edge latency independent of skew.
    always_comb begin
        logic [SW-1:0] sel;
        sel  = '0;
        dl_d = '0;
        av   = '0;
        aw   = '0;
        rise = lane_valid & ~lane_valid_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            dl_d[i][0] = {lane_valid[i], lane_data[8*i +: 8]};
            for (int j = 1; j < DEPTH; j++) begin
                dl_d[i][j] = dl_q[i][j-1];
            end
            sel          = SW'(delay_q[i]) + SW'(1);
            av[i]        = dl_q[i][sel][8];
            aw[8*i +: 8] = dl_q[i][sel][7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        arrived_d    = arrived_q;
        arr_d        = arr_q;
        delay_d      = delay_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        skew_err_d   = 1'b0;
        desync_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    arrived_d = rise;
                    arr_d     = '0;
                    c_d       = DW'(1);
                    if (&rise) begin
                        delay_d = '0;
                        state_d = LOCKED;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
            end
            ACQUIRE: begin
                arrived_d = arrived_q | rise;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (rise[i] && !arrived_q[i]) begin
                        arr_d[i] = c_q;
                    end
                end
                // The last lane always arrives in the current cycle, so c_q is the maximum arrival.
                if (&arrived_d) begin
                    state_d = LOCKED;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        delay_d[i] = c_q - arr_d[i];
                    end
                end else if (c_q == DW'(MAX_SKEW)) begin
                    skew_err_d = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    c_d = c_q + DW'(1);
                end
            end
            LOCKED: begin
                word_valid_d = &av;
                if (word_valid_d) begin
                    word_d = aw;
                end else if (word_valid_q) begin
                    desync_err_d = |av;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (lane_valid == '0) begin
                    arrived_d = '0;
                    arr_d     = '0;
                    c_d       = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // lane_valid_q resets high so lanes already active at reset release never count as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_valid_q <= '1;
            dl_q         <= '0;
            arrived_q    <= '0;
            arr_q        <= '0;
            delay_q      <= '0;
            c_q          <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            skew_err_q   <= 1'b0;
            desync_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_valid_q <= lane_valid;
            dl_q         <= dl_d;
            arrived_q    <= arrived_d;
            arr_q        <= arr_d;
            delay_q      <= delay_d;
            c_q          <= c_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            skew_err_q   <= skew_err_d;
            desync_err_q <= desync_err_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign locked     = (state_q == LOCKED);
    assign lane_delay = delay_q;
    assign skew_err   = skew_err_q;
    assign desync_err = desync_err_q;

endmodule

// File: tb/tb_csi_lane_align.sv
// Directed bench: a 4-lane/skew-3 and a 2-lane/skew-1 aligner, expected words queued at drive time.
module tb_csi_lane_align;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  lv4;
    logic [31:0] ld4;
    logic [31:0] wo4;
    logic        wv4, lk4, se4, de4;
    logic [7:0]  dly4;

    logic [1:0]  lv2;
    logic [15:0] ld2;
    logic [15:0] wo2;
    logic        wv2, lk2, se2, de2;
    logic [1:0]  dly2;

    csi_lane_align #(.NUM_LANES(4), .MAX_SKEW(3)) dut4 (
        .clk(clk), .reset(reset), .lane_valid(lv4), .lane_data(ld4),
        .word_out(wo4), .word_valid(wv4), .locked(lk4), .lane_delay(dly4),
        .skew_err(se4), .desync_err(de4)
    );

    csi_lane_align #(.NUM_LANES(2), .MAX_SKEW(1)) dut2 (
        .clk(clk), .reset(reset), .lane_valid(lv2), .lane_data(ld2),
        .word_out(wo2), .word_valid(wv2), .locked(lk2), .lane_delay(dly2),
        .skew_err(se2), .desync_err(de2)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] hold_dly [2];
    logic [31:0] first_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit two, output logic wv, output logic [31:0] wo, output logic lk,
                          output logic [31:0] dly, output logic se, output logic de);
        wv  = two ? wv2 : wv4;
        wo  = two ? {16'h0, wo2} : wo4;
        lk  = two ? lk2 : lk4;
        dly = two ? {30'h0, dly2} : {24'h0, dly4};
        se  = two ? se2 : se4;
        de  = two ? de2 : de4;
    endtask

    // off/len are per-lane (lane 0 in the low nibble); lane i byte k carries {base+k, i}.
    task automatic run_pkt(input bit two, input logic [3:0][3:0] off, input logic [3:0][3:0] len,
                           input int base, input int tail, input int rst_t);
        int          nl, ms, dw, maxoff, minoff, minlen, maxend, nwords, exp_first;
        int          first_t, n_skew, n_desync, exp_skew, exp_desync;
        bit          lock_ok, lens_differ, lk_seen, lk_after_rst;
        logic [31:0] w, exp_dly, wo, dly;
        logic [3:0]  lv;
        logic [31:0] ld;
        logic        wv, lk, se, de;
        nl = two ? 2 : 4;
        ms = two ? 1 : 3;
        dw = two ? 1 : 2;
        maxoff = 0; minoff = 15; minlen = 15; maxend = 0; lens_differ = 1'b0;
        for (int i = 0; i < nl; i++) begin
            if (int'(off[i]) > maxoff) maxoff = int'(off[i]);
            if (int'(off[i]) < minoff) minoff = int'(off[i]);
            if (int'(len[i]) < minlen) minlen = int'(len[i]);
            if (int'(off[i]) + int'(len[i]) > maxend) maxend = int'(off[i]) + int'(len[i]);
            if (len[i] != len[0]) lens_differ = 1'b1;
        end
        lock_ok = (maxoff - minoff) <= ms;
        nwords  = lock_ok ? minlen : 0;
        if (rst_t >= 0 && rst_t - maxoff - 1 < nwords) nwords = (rst_t - maxoff - 1 > 0) ? rst_t - maxoff - 1 : 0;
        exp_first  = (nwords > 0) ? maxoff + 2 : -1;
        exp_skew   = lock_ok ? 0 : 1;
        exp_desync = (lock_ok && rst_t < 0 && lens_differ) ? 1 : 0;
        if (rst_t >= 0) exp_dly = '0;
        else if (lock_ok) begin
            exp_dly = '0;
            for (int i = 0; i < nl; i++) exp_dly = exp_dly | (32'(maxoff - int'(off[i])) << (dw * i));
        end else exp_dly = hold_dly[two];
        hold_dly[two] = exp_dly;
        for (int k = 0; k < nwords; k++) begin
            w = '0;
            for (int i = 0; i < nl; i++) w[8*i +: 8] = {4'(base + k), 4'(i)};
            exp_q.push_back(w);
        end

        first_t = -1; n_skew = 0; n_desync = 0; lk_seen = 1'b0; lk_after_rst = 1'b0;
        for (int t = 0; t < maxend + tail; t++) begin
            lv = '0;
            ld = '0;
            for (int i = 0; i < nl; i++) begin
                if (t >= int'(off[i]) && t < int'(off[i]) + int'(len[i])) begin
                    lv[i]        = 1'b1;
                    ld[8*i +: 8] = {4'(base + t - int'(off[i])), 4'(i)};
                end
            end
            if (two) begin lv2 = lv[1:0]; ld2 = ld[15:0]; end
            else begin lv4 = lv; ld4 = ld; end
            @(posedge clk);
            #1;
            sample(two, wv, wo, lk, dly, se, de);
            if (wv) begin
                if (first_t < 0) begin first_t = t; first_word = wo; end
                if (exp_q.size() == 0) check("unexpected_word_valid", 32'(wv), 32'd0);
                else check("word_out", wo, exp_q.pop_front());
            end
            if (se) n_skew++;
            if (de) n_desync++;
            if (lk) lk_seen = 1'b1;
            if (rst_t >= 0 && t > rst_t + 2 && lk) lk_after_rst = 1'b1;
            if (t == rst_t) begin
                reset = 1'b1;
                hold_dly[0] = '0;
                hold_dly[1] = '0;
                #1;
                sample(two, wv, wo, lk, dly, se, de);
                check("rst_word_valid", 32'(wv), 32'd0);
                check("rst_locked", 32'(lk), 32'd0);
                check("rst_word_out", wo, 32'd0);
                check("rst_lane_delay", dly, 32'd0);
            end
            if (rst_t >= 0 && t == rst_t + 2) reset = 1'b0;
        end
        if (two) lv2 = '0; else lv4 = '0;

        check("first_word_cycle", 32'(first_t), 32'(exp_first));
        check("words_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("skew_err_pulses", 32'(n_skew), 32'(exp_skew));
        check("desync_err_pulses", 32'(n_desync), 32'(exp_desync));
        check("lane_delay", dly, exp_dly);
        check("locked_seen", 32'(lk_seen), 32'(lock_ok));
        check("locked_at_end", 32'(lk), 32'd0);
        if (rst_t >= 0) check("no_relock_after_reset", 32'(lk_after_rst), 32'd0);
    endtask

    initial begin
        logic        wv, lk, se, de;
        logic [31:0] wo, dly;
        hold_dly[0] = '0;
        hold_dly[1] = '0;
        first_word  = '0;
        reset = 1'b1;
        lv4 = '0; ld4 = '0; lv2 = '0; ld2 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d[0], wv, wo, lk, dly, se, de);
            check("reset_word_valid", 32'(wv), 32'd0);
            check("reset_locked", 32'(lk), 32'd0);
            check("reset_word_out", wo, 32'd0);
            check("reset_lane_delay", dly, 32'd0);
            check("reset_skew_err", 32'(se), 32'd0);
            check("reset_desync_err", 32'(de), 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Zero skew, first bytes 0x10..0x13.
        run_pkt(1'b0, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd4, 4'd4, 4'd4, 4'd4}, 1, 8, -1);
        check("first_word_zero_skew", first_word, 32'h13121110);
        // Lanes 0..3 rise at offsets 0,2,1,3.
        run_pkt(1'b0, {4'd3, 4'd1, 4'd2, 4'd0}, {4'd6, 4'd6, 4'd6, 4'd6}, 0, 8, -1);
        // Lane 3 one cycle beyond the skew window, then a clean zero-skew packet.
        run_pkt(1'b0, {4'd4, 4'd1, 4'd2, 4'd0}, {4'd6, 4'd6, 4'd6, 4'd6}, 2, 8, -1);
        run_pkt(1'b0, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd5, 4'd5, 4'd5, 4'd5}, 3, 8, -1);
        // Lane 1 ends one byte early.
        run_pkt(1'b0, {4'd3, 4'd1, 4'd2, 4'd0}, {4'd6, 4'd6, 4'd5, 4'd6}, 4, 8, -1);
        // Reset after three aligned words, lanes still high at release; then a normal packet.
        run_pkt(1'b0, {4'd3, 4'd1, 4'd2, 4'd0}, {4'd10, 4'd10, 4'd10, 4'd10}, 1, 8, 7);
        run_pkt(1'b0, {4'd3, 4'd1, 4'd2, 4'd0}, {4'd4, 4'd4, 4'd4, 4'd4}, 5, 8, -1);
        // Two-lane back-to-back: the 4-cycle gap lets the second rise land in IDLE after DRAIN.
        run_pkt(1'b1, {4'd0, 4'd0, 4'd1, 4'd0}, {4'd0, 4'd0, 4'd4, 4'd4}, 6, 4, -1);
        run_pkt(1'b1, {4'd0, 4'd0, 4'd0, 4'd1}, {4'd0, 4'd0, 4'd4, 4'd4}, 9, 8, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
